// File: rtl/exec_npc_pkg.sv
// exec_npc_pkg: shared op indices, resolver FSM states and BHT reset value
package exec_npc_pkg;

    localparam int OP_BLT = 0;
    localparam int OP_BNE = 1;
    localparam int OP_J   = 2;
    localparam int OP_JR  = 3;
    localparam int OP_BEX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] BHT_RESET = 2'b01;

endpackage

// File: rtl/npc_bht.sv
// npc_bht: table of 2-bit saturating branch counters, one comb read port, one sync update port
module npc_bht
    import exec_npc_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic             upd_inc,
    input  logic [IDX_W-1:0] upd_idx
);

    logic [1:0] ctr [DEPTH];

    assign rd_taken = ctr[rd_idx][1];

    // counter update saturates at both ends; a same-cycle read still sees the old value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_RESET;
        end else if (upd_en) begin
            ctr[upd_idx] <= upd_inc ? ((ctr[upd_idx] == 2'b11) ? 2'b11 : ctr[upd_idx] + 2'd1)
                                    : ((ctr[upd_idx] == 2'b00) ? 2'b00 : ctr[upd_idx] - 2'd1);
        end
    end

endmodule

// File: rtl/exec_branch_resolve_unit.sv
// exec_branch_resolve_unit: execute-stage branch/jump resolver with registered redirect, timed flush and BHT
// Optional statistics counters are built when EXEC_NPC_STATS_EN is defined.
module exec_branch_resolve_unit
    import exec_npc_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int TARGET_W     = 27,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                ex_valid,
    input  logic [4:0]          ex_op,
    input  logic [PC_W-1:0]     ex_pc,
    input  logic                ex_pred_taken,
    input  logic [PC_W-1:0]     branch_pc,
    input  logic [PC_W-1:0]     seq_pc,
    input  logic                alu_lt,
    input  logic                alu_ne,
    input  logic [TARGET_W-1:0] target,
    input  logic [PC_W-1:0]     rd_val,
    input  logic [PC_W-1:0]     fetch_pc,
    output logic                fetch_pred_taken,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic                flush_active,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PC_W-1:0]  tgt_ext;
    logic [PC_W-1:0]  actual_pc;
    logic             cf_op, is_blt, is_bne, is_j, is_jr, is_bex, is_cond;
    logic             resolve, taken, mispredict;
    logic             unused_bits;

    // jump target is zero-extended into the PC, or truncated when the field is wider
    generate
        if (TARGET_W >= PC_W) begin : g_tgt_trunc
            assign tgt_ext = target[PC_W-1:0];
            if (TARGET_W > PC_W) begin : g_tgt_unused
                logic unused_tgt;
                assign unused_tgt = ^target[TARGET_W-1:PC_W];
            end
        end else begin : g_tgt_ext
            assign tgt_ext = {{(PC_W-TARGET_W){1'b0}}, target};
        end
    endgenerate

    // only the BHT index bits of the PCs matter here
    assign unused_bits = ^{ex_pc[PC_W-1:IDX_W], fetch_pc[PC_W-1:IDX_W]};

    // multi-hot op codes are illegal and behave as a non-control-flow instruction
    assign cf_op   = (ex_op != 5'd0) && ((ex_op & (ex_op - 5'd1)) == 5'd0);
    assign is_blt  = cf_op & ex_op[OP_BLT];
    assign is_bne  = cf_op & ex_op[OP_BNE];
    assign is_j    = cf_op & ex_op[OP_J];
    assign is_jr   = cf_op & ex_op[OP_JR];
    assign is_bex  = cf_op & ex_op[OP_BEX];
    assign is_cond = is_blt | is_bne;

    assign resolve    = ex_valid & !stall & (state == IDLE);
    assign taken      = is_blt ? (!alu_lt & alu_ne) : is_bne ? alu_ne : is_bex ? |rd_val : (is_j | is_jr);
    assign actual_pc  = !taken ? seq_pc : is_cond ? branch_pc : is_jr ? rd_val : tgt_ext;
    assign mispredict = resolve & (is_cond ? (taken != ex_pred_taken) : (is_j | is_jr | (is_bex & taken)));

    npc_bht #(.DEPTH(BHT_DEPTH)) u_bht (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (fetch_pc[IDX_W-1:0]),
        .rd_taken (fetch_pred_taken),
        .upd_en   (resolve & is_cond),
        .upd_inc  (taken),
        .upd_idx  (ex_pc[IDX_W-1:0])
    );

    // FSM state and flush countdown register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state: enter FLUSH on a mispredict, count down while not stalled, leave at zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (mispredict) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end
        end else if (!stall) begin
            if (cnt == '0) state_nxt = IDLE;
            else cnt_nxt = cnt - 1'b1;
        end
    end

    // FSM output: squash younger instructions for the whole FLUSH state
    always_comb begin
        flush_active = (state == FLUSH);
    end

    // redirect is a one-cycle pulse; the corrected PC is held until the next redirect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= actual_pc;
        end
    end

`ifdef EXEC_NPC_STATS_EN
    logic [31:0] br_cnt, mp_cnt;

    // saturating resolved-branch and redirect counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (resolve & cf_op & (br_cnt != 32'hFFFF_FFFF)) br_cnt <= br_cnt + 32'd1;
            if (mispredict & (mp_cnt != 32'hFFFF_FFFF)) mp_cnt <= mp_cnt + 32'd1;
        end
    end

    assign stat_branches    = br_cnt;
    assign stat_mispredicts = mp_cnt;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_exec_branch_resolve_unit.sv
// tb_exec_branch_resolve_unit: directed self-checking bench for the branch resolve unit
module tb_exec_branch_resolve_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_op;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] branch_pc;
    logic [31:0] seq_pc;
    logic        alu_lt;
    logic        alu_ne;
    logic [26:0] target;
    logic [31:0] rd_val;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_active;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int tests = 0;
    int fails = 0;

    exec_branch_resolve_unit dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_op            (ex_op),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .branch_pc        (branch_pc),
        .seq_pc           (seq_pc),
        .alu_lt           (alu_lt),
        .alu_ne           (alu_ne),
        .target           (target),
        .rd_val           (rd_val),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_active     (flush_active),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] pc, input logic pred,
                         input logic [31:0] bpc, input logic lt, input logic ne,
                         input logic [26:0] tgt, input logic [31:0] rd);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_pc         = pc;
        ex_pred_taken = pred;
        branch_pc     = bpc;
        seq_pc        = pc + 32'd1;
        alu_lt        = lt;
        alu_ne        = ne;
        target        = tgt;
        rd_val        = rd;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        check(tag, {31'd0, fetch_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_pc = '0; ex_pred_taken = 1'b0;
        branch_pc = '0; seq_pc = '0; alu_lt = 1'b0; alu_ne = 1'b0; target = '0; rd_val = '0; fetch_pc = '0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();

        // reset state
        check("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_flush", {31'd0, flush_active}, 32'd0);
        check("rst_sb", stat_branches, 32'd0);
        check("rst_sm", stat_mispredicts, 32'd0);
        for (int i = 0; i < 16; i++) pred_at("rst_bht", i, 1'b0);

        // bne taken, predicted not taken
        drive(5'b00010, 32'd5, 1'b0, 32'h40, 1'b0, 1'b1, '0, '0);
        tick();
        ex_valid = 1'b0;
        check("bne_rv", {31'd0, redirect_valid}, 32'd1);
        check("bne_rpc", redirect_pc, 32'h40);
        check("bne_fl0", {31'd0, flush_active}, 32'd1);
        tick();
        check("bne_rv_drop", {31'd0, redirect_valid}, 32'd0);
        check("bne_fl1", {31'd0, flush_active}, 32'd1);
        tick();
        check("bne_fl_end", {31'd0, flush_active}, 32'd0);
        pred_at("bne_bht5", 32'd5, 1'b1);

        // blt at pc=3 taken three times, then not taken twice
        drive(5'b00001, 32'd3, 1'b1, 32'h10, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blt_rv", {31'd0, redirect_valid}, 32'd0);
            pred_at("blt_inc", 32'd3, 1'b1);
        end
        drive(5'b00001, 32'd3, 1'b0, 32'h10, 1'b1, 1'b1, '0, '0);
        tick();
        check("blt_nt_rv", {31'd0, redirect_valid}, 32'd0);
        pred_at("blt_sat_dec", 32'd3, 1'b1);
        tick();
        pred_at("blt_dec2", 32'd3, 1'b0);
        ex_valid = 1'b0;

        // jr followed by a wrong-path bne during FLUSH
        drive(5'b01000, 32'd8, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h1234);
        tick();
        check("jr_rv", {31'd0, redirect_valid}, 32'd1);
        check("jr_rpc", redirect_pc, 32'h1234);
        drive(5'b00010, 32'd9, 1'b0, 32'h80, 1'b0, 1'b1, '0, '0);
        tick();
        ex_valid = 1'b0;
        check("jr_wp_rv", {31'd0, redirect_valid}, 32'd0);
        check("jr_wp_rpc", redirect_pc, 32'h1234);
        tick();
        check("jr_fl_end", {31'd0, flush_active}, 32'd0);
        check("jr_rv_end", {31'd0, redirect_valid}, 32'd0);
        pred_at("jr_wp_bht9", 32'd9, 1'b0);

        // bex: not taken with rstatus 0, taken with rstatus 5
        drive(5'b10000, 32'd10, 1'b0, 32'h0, 1'b0, 1'b0, 27'h7FFFFFF, 32'd0);
        tick();
        check("bex0_rv", {31'd0, redirect_valid}, 32'd0);
        check("bex0_fl", {31'd0, flush_active}, 32'd0);
        rd_val = 32'd5;
        tick();
        ex_valid = 1'b0;
        check("bex5_rv", {31'd0, redirect_valid}, 32'd1);
        check("bex5_rpc", redirect_pc, 32'h07FF_FFFF);
        repeat (2) tick();
        check("bex_fl_end", {31'd0, flush_active}, 32'd0);

        // illegal two-hot op: no redirect, no BHT update
        drive(5'b00011, 32'd6, 1'b0, 32'h55, 1'b0, 1'b1, '0, '0);
        tick();
        ex_valid = 1'b0;
        check("ill_rv", {31'd0, redirect_valid}, 32'd0);
        check("ill_fl", {31'd0, flush_active}, 32'd0);
        pred_at("ill_bht6", 32'd6, 1'b0);

        // a stalled instruction in IDLE does not resolve
        stall = 1'b1;
        drive(5'b00010, 32'd7, 1'b0, 32'h66, 1'b0, 1'b1, '0, '0);
        tick();
        ex_valid = 1'b0;
        stall = 1'b0;
        check("stl_idle_rv", {31'd0, redirect_valid}, 32'd0);
        pred_at("stl_idle_bht7", 32'd7, 1'b0);

        // j mispredict, then stall three cycles inside FLUSH
        drive(5'b00100, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0, 27'h100, '0);
        tick();
        ex_valid = 1'b0;
        check("j_rv", {31'd0, redirect_valid}, 32'd1);
        check("j_rpc", redirect_pc, 32'h100);
        stall = 1'b1;
        tick();
        check("stl_rv_drop", {31'd0, redirect_valid}, 32'd0);
        check("stl_fl1", {31'd0, flush_active}, 32'd1);
        tick();
        check("stl_fl2", {31'd0, flush_active}, 32'd1);
        tick();
        check("stl_fl3", {31'd0, flush_active}, 32'd1);
        stall = 1'b0;
        tick();
        check("stl_fl4", {31'd0, flush_active}, 32'd1);
        tick();
        check("stl_fl_end", {31'd0, flush_active}, 32'd0);

`ifdef EXEC_NPC_STATS_EN
        check("stat_br", stat_branches, 32'd10);
        check("stat_mp", stat_mispredicts, 32'd4);
`else
        check("stat_br", stat_branches, 32'd0);
        check("stat_mp", stat_mispredicts, 32'd0);
`endif

        // asynchronous reset in the middle of FLUSH
        drive(5'b00100, 32'd13, 1'b0, 32'h0, 1'b0, 1'b0, 27'h200, '0);
        tick();
        ex_valid = 1'b0;
        check("rst_mid_fl_pre", {31'd0, flush_active}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_fl", {31'd0, flush_active}, 32'd0);
        check("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_mid_rpc", redirect_pc, 32'd0);
        check("rst_mid_sb", stat_branches, 32'd0);
        pred_at("rst_mid_bht5", 32'd5, 1'b0);
        #3 reset = 1'b1;
        tick();
        check("post_rst_fl", {31'd0, flush_active}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
